load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit sitting directly upstream of the load-extension splitter. Accepts one load or store request at a time from the pipeline, runs a valid/ready transaction on the data-memory bus, and generates byte enables and replicated write data. For loads it returns read data shifted so the addressed byte or halfword sits at bit 0, together with the 3-bit extension option the splitter consumes. Misaligned-access checking and a bus timeout raise an error response.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed in ADDR or WAIT before an error response.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts request
- bus_we  out  1  bus write
- bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- bus_be  out  4  byte enables (stores; 4'b1111 on loads)
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  load data shifted right by 8*addr[1:0]; 0 for stores and errors
- resp_option  out  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
- resp_err  out  1  misaligned, reserved size, or timeout

## Operation
- FSM states: IDLE, ADDR, WAIT, RESP. Reset: IDLE; all outputs 0 except req_ready=1; timeout counter 0.
- IDLE: req_ready=1. When req_valid, latch the request. If it is in error (reserved size, or misaligned when checking is enabled), go to RESP with err set. Otherwise go to ADDR.
- ADDR: bus_valid=1 with bus fields held stable until bus_ready. On handshake, a store goes to RESP and a load goes to WAIT.
- WAIT: on bus_rvalid, capture bus_rdata>>(8*off) and go to RESP. bus_rvalid is ignored in every other state.
- Timeout: the counter clears on entry to ADDR and WAIT and increments each cycle in those states. When it reaches TIMEOUT_CYCLES, go to RESP with err=1 and drop bus_valid.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. No response backpressure.
- Store lanes:
  - byte: wdata = {4{wdata[7:0]}}, be = 4'b0001<<off
  - half: wdata = {2{wdata[15:0]}}, be = 4'b0011<<off
  - word: wdata unchanged, be = 4'b1111
- resp_option is derived from the latched size/unsigned. Word ignores req_unsigned and always reports 000.
- Async reset mid-transaction: return to IDLE immediately, bus_valid drops, no resp_valid. A late bus_rvalid is ignored.

## Timing
- Load with zero-wait bus: accept at cycle 0, bus_valid in cycle 1, bus_rvalid in cycle 2, resp_valid in cycle 3.
- Store: accept at cycle 0, bus handshake in cycle 1, resp_valid in cycle 2.
- Error detected at accept: resp_valid in cycle 1, no bus transaction.
- Throughput: one request per completion. The next accept can occur in the cycle after RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with off[0]=1, or a word access with off≠0, gives resp_err=1.
  - No bus access is made.
- Undefined:
  - Offending low address bits are masked: half uses {addr[1],1'b0}, word uses 00.
  - The access proceeds normally and raises no misalignment error.

## Structure
- lsu_pkg: size encoding constants, resp_option codes, FSM state enum.
- Sub-module lsu_align (combinational): computes be, replicated wdata and the read shift from size and offset.

## Test plan
- Load byte signed, addr 0x103, bus_rdata 0x80FF_1234 → bus_addr 0x100, resp_data 0x0000_0080, resp_option 011, resp_valid in cycle 3.
- Store half, addr 0x202, wdata 0xBEEF → bus_be 1100, bus_wdata 0xBEEF_BEEF, resp_valid in cycle 2, resp_err 0.
- Word load, addr 0x001, with macro defined → resp_err 1 in cycle 1, bus_valid never asserted. Without the macro → bus_addr 0x000, resp_err 0.
- Load with bus_ready held low for 255 cycles → resp_err 1, bus_valid deasserted, return to IDLE; a later bus_rvalid is ignored.
- rst_n pulsed low while in WAIT → all outputs return to reset values immediately; the next request completes normally.
- req_size 11 → resp_err 1 in cycle 1, no bus access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, extension option codes
// handed to the load-extension splitter, and the transaction FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [2:0] OPT_WORD   = 3'b000;
  localparam logic [2:0] OPT_HALF_S = 3'b001;
  localparam logic [2:0] OPT_HALF_U = 3'b010;
  localparam logic [2:0] OPT_BYTE_S = 3'b011;
  localparam logic [2:0] OPT_BYTE_U = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} lsu_state_e;

  // Word (and the reserved size) carry no extension, so unsigned is ignored there.
  function automatic logic [2:0] resp_opt(input logic [1:0] size, input logic uns);
    case (size)
      SIZE_BYTE: return uns ? OPT_BYTE_U : OPT_BYTE_S;
      SIZE_HALF: return uns ? OPT_HALF_U : OPT_HALF_S;
      default:   return OPT_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: byte enables, replicated store data
// and read shift amount, with misaligned offsets masked down to the natural boundary.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  shamt_o
);

  logic [1:0] off_eff;

  always_comb begin
    off_eff    = off_i;
    misalign_o = 1'b0;
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        misalign_o = off_i[0];
        off_eff    = {off_i[1], 1'b0};
        be_o       = 4'b0011 << off_eff;
        wdata_o    = {2{wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        misalign_o = (off_i != 2'b00);
        off_eff    = 2'b00;
      end
      default: begin
        off_eff = 2'b00;
      end
    endcase
    shamt_o = {off_eff, 3'b000};
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time over a valid/ready data bus.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_option,
  output logic        resp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        req_ready_q, bus_valid_q, resp_valid_q, err_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [4:0]  shamt_q;
  logic [2:0]  opt_q;

  logic        al_misalign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [4:0]  al_shamt;
  logic        err_d;
  logic        tmo;

  lsu_align u_align (
    .size_i     (req_size),
    .off_i      (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .misalign_o (al_misalign),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .shamt_o    (al_shamt)
  );

  assign err_d = (req_size == SIZE_RSVD) || (TRAP_EN && al_misalign);
  assign tmo   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
      shamt_q      <= '0;
      opt_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            addr_q      <= {req_addr[31:2], 2'b00};
            be_q        <= req_we ? al_be : 4'b1111;
            wdata_q     <= req_we ? al_wdata : '0;
            shamt_q     <= al_shamt;
            opt_q       <= resp_opt(req_size, req_unsigned);
            rdata_q     <= '0;
            cnt_q       <= '0;
            err_q       <= err_d;
            if (err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q     <= S_ADDR;
              bus_valid_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            cnt_q       <= '0;
            if (we_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (tmo) begin
            bus_valid_q  <= 1'b0;
            err_q        <= 1'b1;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            rdata_q      <= bus_rdata >> shamt_q;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else if (tmo) begin
            err_q        <= 1'b1;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign bus_valid   = bus_valid_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = rdata_q;
  assign resp_option = opt_q;
  assign resp_err    = err_q;

endmodule
